// File: rtl/io_pkg.sv
// Shared definitions for the IO Module input path: FSM state encoding and
// default stream/word geometry.
package io_pkg;

    localparam int IO_BYTE_WIDTH     = 8;
    localparam int IO_BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IO_IDLE    = 3'd0,
        IO_CLEAR   = 3'd1,
        IO_COLLECT = 3'd2,
        IO_WRITE   = 3'd3,
        IO_DONE    = 3'd4
    } io_state_e;

endpackage

// File: rtl/io_byte_packer.sv
// Shift register that packs incoming bytes big-endian into one word and
// flags the byte that completes the word.
module io_byte_packer
    import io_pkg::*;
#(
    parameter int BYTE_WIDTH     = IO_BYTE_WIDTH,
    parameter int BYTES_PER_WORD = IO_BYTES_PER_WORD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 accept,
    input  logic [BYTE_WIDTH-1:0]                byte_in,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] word,
    output logic                                 word_ready
);

    localparam int IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int WORD_W = BYTE_WIDTH * BYTES_PER_WORD;

    logic [IDX_W-1:0]  idx_r;
    logic [WORD_W-1:0] pack_r;

    // Combinational only towards the FSM next-state logic, never to an output.
    assign word_ready = accept && (idx_r == IDX_W'(BYTES_PER_WORD - 1));
    assign word       = pack_r;

    // Byte index and pack register; older bytes move towards the MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= {IDX_W{1'b0}};
            pack_r <= {WORD_W{1'b0}};
        end else if (clear) begin
            idx_r  <= {IDX_W{1'b0}};
            pack_r <= {WORD_W{1'b0}};
        end else if (accept) begin
            pack_r <= {pack_r[WORD_W-BYTE_WIDTH-1:0], byte_in};
            idx_r  <= word_ready ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end
    end

endmodule

// File: rtl/io_load_controller.sv
// IO Module input-path front end: packs the byte stream into words and writes
// them to coefficient memory at the address supplied by the external counter.
module io_load_controller
    import io_pkg::*;
#(
    parameter int BYTE_WIDTH     = IO_BYTE_WIDTH,
    parameter int BYTES_PER_WORD = IO_BYTES_PER_WORD,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 load_start,
    input  logic [ADDR_WIDTH-1:0]                word_count,
    input  logic                                 in_valid,
    input  logic [BYTE_WIDTH-1:0]                in_data,
    output logic                                 in_ready,
    input  logic [ADDR_WIDTH-1:0]                cnt_value,
    output logic                                 cnt_clear,
    output logic                                 cnt_enable,
    output logic                                 cnt_up_down,
    output logic [ADDR_WIDTH-1:0]                cnt_limit,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0] mem_wdata,
    output logic                                 busy,
    output logic                                 done
);

    io_state_e             state_r;
    io_state_e             state_s;
    logic [ADDR_WIDTH-1:0] cnt_limit_r;
    logic                  busy_r;
    logic                  accept_s;
    logic                  word_ready_s;

    assign accept_s = in_valid && (state_r == IO_COLLECT);

    io_byte_packer #(
        .BYTE_WIDTH     (BYTE_WIDTH),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_r == IO_CLEAR),
        .accept     (accept_s),
        .byte_in    (in_data),
        .word       (mem_wdata),
        .word_ready (word_ready_s)
    );

    // State register, latched load length and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IO_IDLE;
            cnt_limit_r <= {ADDR_WIDTH{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IO_IDLE);
            if ((state_r == IO_IDLE) && load_start) begin
                cnt_limit_r <= word_count;
            end
        end
    end

    // Next-state logic plus strobes decoded from the current state only.
    always_comb begin
        state_s    = state_r;
        in_ready   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        case (state_r)
            IO_IDLE: begin
                if (load_start) begin
                    state_s = IO_CLEAR;
                end else begin
                    state_s = IO_IDLE;
                end
            end
            IO_CLEAR: begin
                cnt_clear = 1'b1;
                state_s   = IO_COLLECT;
            end
            IO_COLLECT: begin
                in_ready = 1'b1;
                if (word_ready_s) begin
                    state_s = IO_WRITE;
                end else begin
                    state_s = IO_COLLECT;
                end
            end
            IO_WRITE: begin
                mem_we     = 1'b1;
                cnt_enable = 1'b1;
                // The counter wraps to 0 on this same enable, ready for the next load.
                if (cnt_value == cnt_limit_r) begin
                    state_s = IO_DONE;
                end else begin
                    state_s = IO_COLLECT;
                end
            end
            IO_DONE: begin
                done    = 1'b1;
                state_s = IO_IDLE;
            end
            default: begin
                state_s = IO_IDLE;
            end
        endcase
    end

    assign cnt_up_down = 1'b1;
    assign cnt_limit   = cnt_limit_r;
    assign mem_addr    = cnt_value;
    assign busy        = busy_r;

endmodule

// File: tb/tb_io_load_controller.sv
// Randomized bench for io_load_controller with an external up counter model
// and a transaction-level scoreboard of expected memory writes.
module tb_io_load_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  word_count = 8'h00;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [7:0]  cnt_value = 8'h5A;
    logic        cnt_clear;
    logic        cnt_enable;
    logic        cnt_up_down;
    logic [7:0]  cnt_limit;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    io_load_controller #(.BYTE_WIDTH(8), .BYTES_PER_WORD(4), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cnt_value(cnt_value), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
        .cnt_up_down(cnt_up_down), .cnt_limit(cnt_limit), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Neighbouring up counter: sync clear, wraps to 0 when it reaches its limit.
    always @(posedge clk) begin
        if (cnt_clear)       cnt_value <= 8'h00;
        else if (cnt_enable) cnt_value <= (cnt_value == cnt_limit) ? 8'h00 : cnt_value + 8'h01;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: a load is a list of bytes grouped four at a time.
    bit          mon_en = 1'b0;
    bit          m_idle = 1'b1;
    bit          we_due, done_due, clear_due, load_done;
    int          wc_model, words_written, clear_seen;
    logic [7:0]  acc_q[$];
    logic [31:0] exp_w[$];
    logic [31:0] wr_log[0:255];

    task automatic reset_model();
        m_idle = 1'b1; we_due = 1'b0; done_due = 1'b0; clear_due = 1'b0;
        words_written = 0;
        acc_q.delete(); exp_w.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            bit e_we, e_done, e_clr;
            e_we = we_due; e_done = done_due; e_clr = clear_due;
            we_due = 1'b0; done_due = 1'b0; clear_due = 1'b0;
            check_eq("busy", busy, !m_idle);
            check_eq("cnt_clear", cnt_clear, e_clr);
            check_eq("mem_we", mem_we, e_we);
            check_eq("cnt_enable", cnt_enable, e_we);
            check_eq("done", done, e_done);
            check_eq("cnt_up_down", cnt_up_down, 1'b1);
            if (!m_idle) check_eq("cnt_limit", cnt_limit, wc_model);
            if (cnt_clear) clear_seen++;
            if (e_we && exp_w.size() > 0) begin
                logic [31:0] w;
                w = exp_w.pop_front();
                check_eq("mem_addr", mem_addr, words_written);
                check_eq("mem_wdata", mem_wdata, w);
                wr_log[words_written[7:0]] = mem_wdata;
                if (words_written == wc_model) done_due = 1'b1;
                words_written++;
            end
            if (load_start && m_idle) begin
                m_idle = 1'b0; clear_due = 1'b1;
                wc_model = word_count; words_written = 0;
            end
            if (e_done) begin
                m_idle = 1'b1; load_done = 1'b1;
            end
            if (in_valid && in_ready) begin
                acc_q.push_back(in_data);
                if (acc_q.size() == 4) begin
                    exp_w.push_back({acc_q[0], acc_q[1], acc_q[2], acc_q[3]});
                    acc_q.delete();
                    we_due = 1'b1;
                end
            end
        end
    end

    // mode: 0 = counting bytes from 0x01 with valid held, 1 = toggling valid,
    // 2 = random valid and data. abort_at > 0 stops after that many accepted bytes.
    task automatic run_load(input logic [7:0] wc, input int mode, input bit poke, input int abort_at);
        int n, acc_cnt;
        logic acc;
        logic [7:0] cur;
        cur = (mode == 0 || mode == 1) ? 8'h01 : 8'($urandom);
        load_done = 1'b0;
        word_count = wc; load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0; word_count = 8'($urandom);
        n = 0; acc_cnt = 0;
        while (!load_done && n < 4000 && !(abort_at > 0 && acc_cnt >= abort_at)) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = n[0];
                default: in_valid = 1'($urandom);
            endcase
            in_data = cur;
            if (poke && $urandom_range(0, 3) == 0) begin
                load_start = 1'b1; word_count = 8'($urandom);
            end else begin
                load_start = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                acc_cnt++;
                cur = (mode == 0 || mode == 1) ? cur + 8'h01 : 8'($urandom);
            end
            n++;
        end
        in_valid = 1'b0; load_start = 1'b0;
        if (abort_at == 0) check_eq("load_finished", load_done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_mem_we"}, mem_we, 1'b0);
        check_eq({tag, "_cnt_clear"}, cnt_clear, 1'b0);
        check_eq({tag, "_cnt_enable"}, cnt_enable, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_cnt_limit"}, cnt_limit, 8'h00);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check_eq({tag, "_cnt_up_down"}, cnt_up_down, 1'b1);
    endtask

    initial begin
        int c0;
        reset_model();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Counting bytes with valid held, then with bubbles: identical words.
        run_load(8'd2, 0, 1'b0, 0);
        check_eq("t1_word0", wr_log[0], 32'h01020304);
        check_eq("t1_word1", wr_log[1], 32'h05060708);
        check_eq("t1_word2", wr_log[2], 32'h090A0B0C);
        repeat (2) @(posedge clk); #1;
        wr_log[0] = 32'h0; wr_log[1] = 32'h0; wr_log[2] = 32'h0;
        run_load(8'd2, 1, 1'b0, 0);
        check_eq("t2_word0", wr_log[0], 32'h01020304);
        check_eq("t2_word1", wr_log[1], 32'h05060708);
        check_eq("t2_word2", wr_log[2], 32'h090A0B0C);

        // Spurious start pulses mid-load.
        run_load(8'd3, 2, 1'b1, 0);

        // Asynchronous reset in the middle of the second word.
        run_load(8'd2, 2, 1'b0, 6);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        check_eq("midreset_held_we", mem_we, 1'b0);
        @(posedge clk); #1;
        reset_model();
        rst_n = 1'b1;
        mon_en = 1'b1;
        run_load(8'd1, 2, 1'b0, 0);

        // Single-word load leaves the counter at 0.
        run_load(8'd0, 2, 1'b0, 0);
        check_eq("t5_cnt_zero", cnt_value, 8'h00);

        // Back-to-back loads, each must go through CLEAR.
        run_load(8'd4, 2, 1'b0, 0);
        c0 = clear_seen;
        run_load(8'd1, 2, 1'b0, 0);
        check_eq("t6_clear_seen", clear_seen - c0, 1);
        check_eq("t6_cnt_zero", cnt_value, 8'h00);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_load(8'($urandom_range(0, 7)), 2, 1'($urandom), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("final_idle_busy", busy, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
